// File: rtl/jtag_tap_if.sv
// ---------------------------------------------------------------------------
// jtag_tap_if
//
// Bundle of the JTAG pin signals and the boundary-scan chain control signals
// that connect jtag_tap_ctrl to the outside world. tck and rst are not part
// of the bundle; they stay plain module ports.
//
// Signal summary
//   tms, tdi          : JTAG pins into the TAP, sampled on rising tck
//   tdo, tdo_en       : JTAG serial output and its output enable
//   bsr_sdi, bsr_sdo  : serial in/out of the boundary-scan register chain
//   bsr_mode          : BSR cells drive pins from their update latch (EXTEST)
//   bsr_shift_dr      : BSR shift select (1 = shift, 0 = capture)
//   bsr_clk_dr        : BSR capture/shift enable
//   bsr_update_dr     : BSR update enable
//   ir_active         : currently active instruction
//   tap_state         : current TAP state encoding, for debug/checkers
//
// Modports
//   master : the JTAG host / test environment side
//   slave  : the TAP controller side
//
// There is no valid/ready handshake on this bundle: every transfer is
// qualified only by the TAP state, and one bit moves per rising tck while
// the TAP sits in a SHIFT state.
// ---------------------------------------------------------------------------
interface jtag_tap_if #(
    parameter int IR_WIDTH = 4
);
    logic                tms;
    logic                tdi;
    logic                tdo;
    logic                tdo_en;
    logic                bsr_sdi;
    logic                bsr_sdo;
    logic                bsr_mode;
    logic                bsr_shift_dr;
    logic                bsr_clk_dr;
    logic                bsr_update_dr;
    logic [IR_WIDTH-1:0] ir_active;
    logic [3:0]          tap_state;

    modport master (
        output tms,
        output tdi,
        output bsr_sdo,
        input  tdo,
        input  tdo_en,
        input  bsr_sdi,
        input  bsr_mode,
        input  bsr_shift_dr,
        input  bsr_clk_dr,
        input  bsr_update_dr,
        input  ir_active,
        input  tap_state
    );

    modport slave (
        input  tms,
        input  tdi,
        input  bsr_sdo,
        output tdo,
        output tdo_en,
        output bsr_sdi,
        output bsr_mode,
        output bsr_shift_dr,
        output bsr_clk_dr,
        output bsr_update_dr,
        output ir_active,
        output tap_state
    );
endinterface

// File: rtl/jtag_tap_ctrl.sv
// ---------------------------------------------------------------------------
// jtag_tap_ctrl
//
// IEEE 1149.1-style TAP controller for the boundary-scan chain around the
// core I/O. Decodes TMS into the 16-state TAP machine, holds the
// instruction register, implements the BYPASS and IDCODE data registers,
// generates the BSR capture/shift/update enables and mode select, and
// muxes the selected register onto TDO.
//
// Parameters
//   IR_WIDTH   : instruction register width (>= 2)
//   IDCODE_VAL : value captured into the ID register (bit 0 must be 1)
//
// Ports
//   tck  : test clock, all state changes on its rising edge
//   rst  : asynchronous, active-high reset (forces Test-Logic-Reset)
//   jtag : jtag_tap_if.slave bundle (pins, BSR chain controls, debug)
//
// Instructions
//   EXTEST = 0, SAMPLE/PRELOAD = 1, IDCODE = 2, BYPASS = all ones.
//   Every other code behaves as BYPASS.
//
// All shift registers shift LSB first: tdi enters the MSB, bit 0 is
// presented on tdo. tdo, tdo_en and the BSR enables are decoded
// combinationally from the registered state, so they are glitch-free with
// respect to tms/tdi and only change after a tck edge or reset.
// ---------------------------------------------------------------------------
module jtag_tap_ctrl #(
    parameter int          IR_WIDTH   = 4,
    parameter logic [31:0] IDCODE_VAL = 32'h1000_0FFF
) (
    input logic       tck,
    input logic       rst,
    jtag_tap_if.slave jtag
);

    // Standard 1149.1 state encoding, so tap_state reads like a datasheet.
    typedef enum logic [3:0] {
        TLR      = 4'hF,
        RTI      = 4'hC,
        SEL_DR   = 4'h7,
        CAP_DR   = 4'h6,
        SHIFT_DR = 4'h2,
        EX1_DR   = 4'h1,
        PAUSE_DR = 4'h3,
        EX2_DR   = 4'h0,
        UPD_DR   = 4'h5,
        SEL_IR   = 4'h4,
        CAP_IR   = 4'hE,
        SHIFT_IR = 4'hA,
        EX1_IR   = 4'h9,
        PAUSE_IR = 4'hB,
        EX2_IR   = 4'h8,
        UPD_IR   = 4'hD
    } tap_state_e;

    localparam logic [IR_WIDTH-1:0] IR_EXTEST  = '0;
    localparam logic [IR_WIDTH-1:0] IR_SAMPLE  = IR_WIDTH'(1);
    localparam logic [IR_WIDTH-1:0] IR_IDCODE  = IR_WIDTH'(2);
    // Fixed capture pattern: ...01, lets a host check IR chain integrity.
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(1);

    tap_state_e          state;
    tap_state_e          state_next;

    logic [IR_WIDTH-1:0] ir_shift;
    logic [IR_WIDTH-1:0] ir_active;
    logic [31:0]         id_shift;
    logic                bypass_reg;

    logic                sel_bsr;
    logic                sel_id;

    // -----------------------------------------------------------------------
    // TAP state machine
    // -----------------------------------------------------------------------
    always_ff @(posedge tck or posedge rst) begin
        if (rst) begin
            state <= TLR;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            TLR:      state_next = jtag.tms ? TLR      : RTI;
            RTI:      state_next = jtag.tms ? SEL_DR   : RTI;
            SEL_DR:   state_next = jtag.tms ? SEL_IR   : CAP_DR;
            CAP_DR:   state_next = jtag.tms ? EX1_DR   : SHIFT_DR;
            SHIFT_DR: state_next = jtag.tms ? EX1_DR   : SHIFT_DR;
            EX1_DR:   state_next = jtag.tms ? UPD_DR   : PAUSE_DR;
            PAUSE_DR: state_next = jtag.tms ? EX2_DR   : PAUSE_DR;
            EX2_DR:   state_next = jtag.tms ? UPD_DR   : SHIFT_DR;
            UPD_DR:   state_next = jtag.tms ? SEL_DR   : RTI;
            SEL_IR:   state_next = jtag.tms ? TLR      : CAP_IR;
            CAP_IR:   state_next = jtag.tms ? EX1_IR   : SHIFT_IR;
            SHIFT_IR: state_next = jtag.tms ? EX1_IR   : SHIFT_IR;
            EX1_IR:   state_next = jtag.tms ? UPD_IR   : PAUSE_IR;
            PAUSE_IR: state_next = jtag.tms ? EX2_IR   : PAUSE_IR;
            EX2_IR:   state_next = jtag.tms ? UPD_IR   : SHIFT_IR;
            UPD_IR:   state_next = jtag.tms ? SEL_DR   : RTI;
            default:  state_next = TLR;
        endcase
    end

    // -----------------------------------------------------------------------
    // Instruction register
    // -----------------------------------------------------------------------
    always_ff @(posedge tck or posedge rst) begin
        if (rst) begin
            ir_shift  <= '0;
            ir_active <= IR_IDCODE;
        end else begin
            case (state)
                CAP_IR:   ir_shift <= IR_CAPTURE;
                SHIFT_IR: ir_shift <= {jtag.tdi, ir_shift[IR_WIDTH-1:1]};
                default:  ir_shift <= ir_shift;
            endcase

            // Forcing on the edge that enters TLR (not one edge later) makes
            // bsr_mode drop at the same moment the TAP reaches TLR.
            if (state_next == TLR) begin
                ir_active <= IR_IDCODE;
            end else if (state == UPD_IR) begin
                ir_active <= ir_shift;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Data register selection
    // -----------------------------------------------------------------------
    always_comb begin
        sel_bsr = (ir_active == IR_EXTEST) || (ir_active == IR_SAMPLE);
        sel_id  = (ir_active == IR_IDCODE);
    end

    // -----------------------------------------------------------------------
    // IDCODE and BYPASS data registers
    // -----------------------------------------------------------------------
    always_ff @(posedge tck or posedge rst) begin
        if (rst) begin
            id_shift   <= '0;
            bypass_reg <= 1'b0;
        end else begin
            if (sel_id && state == CAP_DR) begin
                id_shift <= IDCODE_VAL;
            end else if (sel_id && state == SHIFT_DR) begin
                id_shift <= {jtag.tdi, id_shift[31:1]};
            end

            // Bypass is a single stage: capture 0, then tdi flows through
            // with one cycle of delay.
            if (state == CAP_DR) begin
                bypass_reg <= 1'b0;
            end else if (state == SHIFT_DR) begin
                bypass_reg <= jtag.tdi;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs, decoded from registered state only
    // -----------------------------------------------------------------------
    always_comb begin
        jtag.tdo_en        = (state == SHIFT_IR) || (state == SHIFT_DR);
        jtag.bsr_sdi       = jtag.tdi;
        jtag.bsr_mode      = (ir_active == IR_EXTEST);
        jtag.bsr_clk_dr    = sel_bsr && ((state == CAP_DR) || (state == SHIFT_DR));
        jtag.bsr_shift_dr  = sel_bsr && (state == SHIFT_DR);
        jtag.bsr_update_dr = sel_bsr && (state == UPD_DR);
        jtag.ir_active     = ir_active;
        jtag.tap_state     = state;

        jtag.tdo = 1'b0;
        if (state == SHIFT_IR) begin
            jtag.tdo = ir_shift[0];
        end else if (state == SHIFT_DR) begin
            if (sel_bsr) begin
                jtag.tdo = jtag.bsr_sdo;
            end else if (sel_id) begin
                jtag.tdo = id_shift[0];
            end else begin
                jtag.tdo = bypass_reg;
            end
        end
    end

endmodule
